// File: rtl/code_lock.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : code_lock                                                     |
// | Purpose  : Keypad combination lock with parametrised button count and    |
// |            code length. Features edge-detected presses, multi-press      |
// |            rejection, full-code compare, idle timeout, failed-attempt    |
// |            lockout and in-field reprogramming while open.                |
// | Ports    : clk, reset (async, active-high)                               |
// |            btn[NUM_BTN]  - synchronous button levels                     |
// |            prog_en       - reprogram request (honoured in OPEN only)     |
// |            unlock, green_led, red_led, locked_out - registered status    |
// |            fail_cnt      - consecutive wrong-code count                  |
// |            state_o       - IDLE=0 ENTRY=1 OPEN=2 ERROR=3 LOCKOUT=4 PROG=5|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module code_lock #(
   parameter int NUM_BTN        = 4,
   parameter int CODE_LEN       = 4,
   parameter logic [CODE_LEN*((NUM_BTN > 1) ? $clog2(NUM_BTN) : 1)-1:0] CODE_INIT = 8'hD8,
   parameter int IDLE_TIMEOUT   = 10,
   parameter int UNLOCK_CYCLES  = 3,
   parameter int ERR_CYCLES     = 2,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_BTN-1:0]               btn,
   input  logic                             prog_en,
   output logic                             unlock,
   output logic                             green_led,
   output logic                             red_led,
   output logic                             locked_out,
   output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
   output logic [2:0]                       state_o
);

   localparam int BW  = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
   localparam int CW  = CODE_LEN * BW;
   localparam int PW  = $clog2(CODE_LEN + 1);
   localparam int FW  = $clog2(MAX_FAILS + 1);
   // One shared timer serves every dwell/timeout; size it for the longest.
   localparam int T_A  = (IDLE_TIMEOUT > UNLOCK_CYCLES) ? IDLE_TIMEOUT : UNLOCK_CYCLES;
   localparam int T_B  = (ERR_CYCLES > LOCKOUT_CYCLES) ? ERR_CYCLES : LOCKOUT_CYCLES;
   localparam int TMAX = (T_A > T_B) ? T_A : T_B;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_OPEN    = 3'd2,
      S_ERROR   = 3'd3,
      S_LOCKOUT = 3'd4,
      S_PROG    = 3'd5
   } state_t;

   state_t              r_state;
   logic [TW-1:0]       r_tmr;
   logic [PW-1:0]       r_pos;
   logic                r_wrong;
   logic [CW-1:0]       r_entry;   // entry buffer, doubles as PROG shadow
   logic [CW-1:0]       r_code;
   logic [NUM_BTN-1:0]  r_btn_q;

   logic [NUM_BTN-1:0]  w_rise;
   logic                w_any, w_valid, w_bad;
   logic [BW-1:0]       w_digit;
   logic [CW-1:0]       w_ins;
   logic                w_last, w_match;
   logic [FW-1:0]       w_fail_inc;
   logic                w_go_idle, w_go_err, w_go_open;

   state_t              w_state_n;
   logic [TW-1:0]       w_tmr_n;
   logic [PW-1:0]       w_pos_n;
   logic                w_wrong_n;
   logic [CW-1:0]       w_entry_n;
   logic [CW-1:0]       w_code_n;
   logic [FW-1:0]       w_fail_n;
   logic                w_unlock_n, w_green_n, w_red_n, w_lock_n;

   // Press decode
   always_comb begin
      w_rise  = btn & ~r_btn_q;
      w_any   = |w_rise;
      w_valid = $onehot(w_rise);
      w_bad   = w_any & ~w_valid;
      w_digit = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (w_rise[i]) w_digit = BW'(i);
      end
      // Buffer with the current digit dropped into slot r_pos; the buffer is
      // always clear in IDLE, so the same path serves the first digit.
      w_ins = r_entry;
      for (int k = 0; k < CODE_LEN; k++) begin
         if (r_pos == PW'(k)) w_ins[k*BW +: BW] = w_digit;
      end
      w_last     = (r_pos == PW'(CODE_LEN - 1));
      w_match    = (w_ins == r_code) & ~r_wrong;
      w_fail_inc = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + FW'(1);
   end

   // Next-state logic
   always_comb begin
      w_state_n = r_state;
      w_tmr_n   = r_tmr;
      w_pos_n   = r_pos;
      w_wrong_n = r_wrong;
      w_entry_n = r_entry;
      w_code_n  = r_code;
      w_fail_n  = fail_cnt;
      w_go_idle = 1'b0;
      w_go_err  = 1'b0;
      w_go_open = 1'b0;

      case (r_state)
         S_IDLE, S_ENTRY: begin
            if (r_state == S_IDLE && w_bad) begin
               w_go_err = 1'b1;
            end else if (w_any) begin
               // An invalid press in ENTRY still consumes a digit slot.
               if (w_last) begin
                  if (w_valid && w_match) w_go_open = 1'b1;
                  else                    w_go_err  = 1'b1;
               end else begin
                  w_state_n = S_ENTRY;
                  w_tmr_n   = '0;
                  w_pos_n   = r_pos + PW'(1);
                  w_wrong_n = r_wrong | w_bad;
                  if (w_valid) w_entry_n = w_ins;
               end
            end else if (r_state == S_ENTRY) begin
               if (r_tmr == TW'(IDLE_TIMEOUT - 1)) w_go_idle = 1'b1;
               else                                 w_tmr_n   = r_tmr + TW'(1);
            end
         end
         S_OPEN: begin
            if (prog_en) begin
               w_state_n = S_PROG;
               w_tmr_n   = '0;
            end else if (r_tmr == TW'(UNLOCK_CYCLES - 1)) begin
               w_go_idle = 1'b1;
            end else begin
               w_tmr_n = r_tmr + TW'(1);
            end
         end
         S_PROG: begin
            if (w_bad) begin
               w_go_idle = 1'b1;
            end else if (w_valid) begin
               if (w_last) begin
                  w_code_n  = w_ins;
                  w_go_idle = 1'b1;
               end else begin
                  w_pos_n   = r_pos + PW'(1);
                  w_entry_n = w_ins;
                  w_tmr_n   = '0;
               end
            end else if (r_tmr == TW'(IDLE_TIMEOUT - 1)) begin
               w_go_idle = 1'b1;
            end else begin
               w_tmr_n = r_tmr + TW'(1);
            end
         end
         S_ERROR: begin
            if (r_tmr == TW'(ERR_CYCLES - 1)) begin
               if (fail_cnt == FW'(MAX_FAILS)) begin
                  w_state_n = S_LOCKOUT;
                  w_tmr_n   = '0;
               end else begin
                  w_go_idle = 1'b1;
               end
            end else begin
               w_tmr_n = r_tmr + TW'(1);
            end
         end
         S_LOCKOUT: begin
            if (r_tmr == TW'(LOCKOUT_CYCLES - 1)) begin
               w_fail_n  = '0;
               w_go_idle = 1'b1;
            end else begin
               w_tmr_n = r_tmr + TW'(1);
            end
         end
         default: w_go_idle = 1'b1;
      endcase

      // Every exit clears the entry buffer, keeping it empty in IDLE.
      if (w_go_idle || w_go_err || w_go_open) begin
         w_tmr_n   = '0;
         w_pos_n   = '0;
         w_wrong_n = 1'b0;
         w_entry_n = '0;
      end
      if (w_go_idle) w_state_n = S_IDLE;
      if (w_go_err) begin
         w_state_n = S_ERROR;
         w_fail_n  = w_fail_inc;
      end
      if (w_go_open) begin
         w_state_n = S_OPEN;
         w_fail_n  = '0;
      end

      // Outputs decoded from the next state so they move on the same edge.
      w_unlock_n = (w_state_n == S_OPEN);
      w_green_n  = (w_state_n == S_OPEN) |
                   ((w_state_n == S_PROG) & ((r_state != S_PROG) | ~green_led));
      w_red_n    = (w_state_n == S_ERROR) |
                   ((w_state_n == S_LOCKOUT) & ~w_tmr_n[0]);
      w_lock_n   = (w_state_n == S_LOCKOUT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_tmr      <= '0;
         r_pos      <= '0;
         r_wrong    <= 1'b0;
         r_entry    <= '0;
         r_code     <= CODE_INIT;
         r_btn_q    <= '0;
         fail_cnt   <= '0;
         unlock     <= 1'b0;
         green_led  <= 1'b0;
         red_led    <= 1'b0;
         locked_out <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_tmr      <= w_tmr_n;
         r_pos      <= w_pos_n;
         r_wrong    <= w_wrong_n;
         r_entry    <= w_entry_n;
         r_code     <= w_code_n;
         r_btn_q    <= btn;
         fail_cnt   <= w_fail_n;
         unlock     <= w_unlock_n;
         green_led  <= w_green_n;
         red_led    <= w_red_n;
         locked_out <= w_lock_n;
      end
   end

   assign state_o = r_state;

endmodule
`default_nettype wire

// File: doc/code_lock.md
Name: code_lock

Overview:
Parametrised keypad combination lock driving a door-release output and status LEDs. Generalises the fixed 4-button/4-digit lock:
- configurable button count and code length
- edge-detected presses with multi-press rejection
- full-code compare, so no per-digit leak of which digit was wrong
- idle timeout, failed-attempt lockout
- in-field reprogramming of the code while unlocked

Sits between the debounced/synchronised button bank and the door actuator/LED drivers.

Parameters:
NUM_BTN, 4, number of buttons; BW = max(1,$clog2(NUM_BTN)) bits per code digit.
CODE_LEN, 4, digits per code.
CODE_INIT, 8'hD8, reset code, CODE_LEN*BW bits, digit 0 in LSBs (default = sequence 0,2,1,3).
IDLE_TIMEOUT, 10, cycles without a press before partial entry is abandoned.
UNLOCK_CYCLES, 3, cycles unlock/green held.
ERR_CYCLES, 2, cycles red held after a wrong code.
MAX_FAILS, 3, consecutive wrong codes that trigger lockout.
LOCKOUT_CYCLES, 16, lockout duration in cycles.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  asynchronous, active-high.
btn  in  NUM_BTN  button levels, already synchronous to clk.
prog_en  in  1  request code reprogramming; honoured only in OPEN.
unlock  out  1  door release.
green_led  out  1  success/programming indicator.
red_led  out  1  error/lockout indicator.
locked_out  out  1  high throughout LOCKOUT.
fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive wrong-code count.
state_o  out  3  FSM state: IDLE=0, ENTRY=1, OPEN=2, ERROR=3, LOCKOUT=4, PROG=5.

Behaviour:
- Reset (async):
  - state IDLE; all outputs 0; fail_cnt 0; btn_q 0.
  - All counters and the entry buffer cleared; stored code = CODE_INIT.
- Press event, evaluated combinationally on each edge:
  - rise = btn & ~btn_q; btn_q registers btn every cycle.
  - rise one-hot: valid press, digit = index of the set bit.
  - rise with more than one bit set: invalid press.
  - Held buttons produce no further events.
- All outputs registered, decoded from next state: they change on the same edge that causes the transition (zero extra latency).
- IDLE:
  - Valid press: store digit 0, pos=1, go ENTRY (CODE_LEN=1: compare immediately, as below).
  - Invalid press: go ERROR.
- ENTRY:
  - Each valid press stores the digit at pos and increments pos.
  - Invalid press marks the attempt wrong but still counts as a digit.
  - The press that makes pos==CODE_LEN triggers a compare of all digits against the stored code: all match → OPEN; otherwise → ERROR.
  - idle_cnt clears on any press and increments otherwise; reaching IDLE_TIMEOUT → IDLE, buffer cleared, fail_cnt unchanged.
- OPEN:
  - unlock=1, green=1 for exactly UNLOCK_CYCLES cycles, then IDLE. fail_cnt cleared on entry.
  - Presses ignored.
  - prog_en sampled 1 in any OPEN cycle → PROG; unlock drops on that edge.
- PROG:
  - green toggles every cycle, starting at 1; unlock=0.
  - Collect CODE_LEN valid presses into a shadow buffer; on the last one, commit to the stored code and go IDLE.
  - Invalid press or IDLE_TIMEOUT without a press → IDLE, stored code unchanged.
- ERROR:
  - red=1 for ERR_CYCLES; fail_cnt increments (saturating at MAX_FAILS) on the entering edge.
  - Exit: fail_cnt==MAX_FAILS → LOCKOUT, else IDLE.
  - Presses ignored.
- LOCKOUT:
  - locked_out=1; red = lock-timer bit 0, starting at 1.
  - All presses ignored; prog_en ignored.
  - After LOCKOUT_CYCLES → IDLE, fail_cnt=0.
- Simultaneous events: a timeout and a press on the same cycle resolve in favour of the press. prog_en in any state other than OPEN is ignored.
- Reset mid-operation (including mid-PROG) restores CODE_INIT; no partial commit is ever visible.

Test Plan:
1. Defaults; press 0,2,1,3 one per 2 cycles → unlock=1 and green=1 from the edge of the 4th press, for 3 cycles; fail_cnt=0.
2. Press 0,2,1,2 → no unlock; red=1 for 2 cycles; fail_cnt=1. Repeat twice more → locked_out=1, red toggles for 16 cycles; presses during lockout are ignored; then IDLE, fail_cnt=0.
3. Press 0,2 then idle 10 cycles → state IDLE. Then 1,3 alone (2 presses) → no unlock. Full 0,2,1,3 → unlock.
4. Hold btn[0] for 5 cycles → one digit only. Press btn[1]+btn[2] together as digit 2 → attempt fails after 4 digits.
5. Unlock, assert prog_en, enter 3,3,0,1 → stored code updated. 0,2,1,3 → error; 3,3,0,1 → unlock. Abort PROG by a double press → old code still works.
6. Assert reset during ENTRY and during PROG → all outputs 0 immediately, state IDLE, CODE_INIT active.
